// File: rtl/booth_multiplier_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package mult_pkg;

  localparam int ITERS = 32;
  localparam int WIDTH = 32;
  localparam int ACC_W = 33;
  localparam int CNT_W = $clog2(ITERS);

  // Booth recoding pairs {mq[0], q_1}
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The product fits in 32 signed bits only when product[63:31] is all
  // zeros or all ones.
  function automatic logic product_overflow(input logic [WIDTH:0] hi);
    return ~((&hi) | ~(|hi));
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of
// the multiplicand, then arithmetic right shift of {acc, mq, q_1}.
module booth_step
  import mult_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic             q1_i,
  input  logic [ACC_W-1:0] mcand_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [WIDTH-1:0] mq_o,
  output logic             q1_o
);

  logic [ACC_W-1:0] sum;

  // Select add, subtract or pass-through from the current Booth pair
  always_comb begin
    sum = acc_i;
    case ({mq_i[0], q1_i})
      BOOTH_ADD: sum = acc_i + mcand_i;
      BOOTH_SUB: sum = acc_i - mcand_i;
      default:   sum = acc_i;
    endcase
  end

  // Arithmetic right shift of the concatenated {acc, mq, q_1}
  always_comb begin
    acc_o = {sum[ACC_W-1], sum[ACC_W-1:1]};
    mq_o  = {sum[0], mq_i[WIDTH-1:1]};
    q1_o  = mq_i[0];
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential 32x32 signed Booth multiplier with start/ready handshake.
// Returns product[31:0] and an overflow flag when the product does not
// fit in 32 signed bits. A start in any state restarts with new operands.
module booth_multiplier
  import mult_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] out,
  output logic             exp,
  output logic             ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_e           state_q;
  logic [ACC_W-1:0] mcand_q;
  logic [ACC_W-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic             q1_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] out_q;
  logic             exp_q;
  logic             ready_q;
  logic             busy_q;

  logic [ACC_W-1:0] acc_d;
  logic [WIDTH-1:0] mq_d;
  logic             q1_d;

  booth_step u_step (
    .acc_i   (acc_q),
    .mq_i    (mq_q),
    .q1_i    (q1_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_d),
    .mq_o    (mq_d),
    .q1_o    (q1_d)
  );

  // FSM, iteration datapath and registered handshake/result outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      out_q   <= '0;
      exp_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start) begin
      // A start always wins: abort whatever is running and load fresh operands
      state_q <= RUN;
      mcand_q <= {A_in[WIDTH-1], A_in};
      acc_q   <= '0;
      mq_q    <= B_in;
      q1_q    <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        RUN: begin
          acc_q   <= acc_d;
          mq_q    <= mq_d;
          q1_q    <= q1_d;
          count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (count_q == LAST_CNT) begin
            // Final step: product is {acc_d[31:0], mq_d}
            state_q <= DONE;
            out_q   <= mq_d;
            exp_q   <= product_overflow({acc_d[WIDTH-1:0], mq_d[WIDTH-1]});
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out   = out_q;
  assign exp   = exp_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed vector table, random
// operands against a plain-arithmetic reference, restart and reset cases.
module tb_booth_multiplier;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] out;
  logic        exp;
  logic        ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_out;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want_out;
    logic        want_ovf;
  } vec_t;

  vec_t vecs[6];

  booth_multiplier dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .A_in  (A_in),
    .B_in  (B_in),
    .out   (out),
    .exp   (exp),
    .ready (ready),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Reference: full 64-bit signed product with ordinary arithmetic
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic v);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    o = p[31:0];
    v = (p != longint'($signed(p[31:0])));
  endfunction

  // Assert start for one edge (E0) and check the immediate response
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clock);
    start = 1'b1;
    A_in  = a;
    B_in  = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    A_in  = $urandom;
    B_in  = $urandom;
    chk1({tag, " busy at E0"}, busy, 1'b1);
    chk1({tag, " ready at E0"}, ready, 1'b0);
    chk32({tag, " out held at E0"}, out, last_out);
  endtask

  // Edges E1..E31 must show busy with no ready; E32 delivers the result
  task automatic finish_op(input logic [31:0] want_out, input logic want_ovf, input string tag);
    int bad_hs;
    int bad_hold;
    bad_hs   = 0;
    bad_hold = 0;
    for (int i = 1; i < 32; i++) begin
      @(posedge clock);
      #1;
      if (ready !== 1'b0 || busy !== 1'b1) bad_hs++;
      if (out !== last_out) bad_hold++;
    end
    chk32({tag, " handshake E1..E31"}, 32'(bad_hs), 32'd0);
    chk32({tag, " out held E1..E31"}, 32'(bad_hold), 32'd0);
    @(posedge clock);
    #1;
    chk1({tag, " ready at E32"}, ready, 1'b1);
    chk1({tag, " busy at E32"}, busy, 1'b0);
    chk32({tag, " out"}, out, want_out);
    chk1({tag, " exp"}, exp, want_ovf);
    last_out = want_out;
  endtask

  // One idle edge after DONE: ready drops, result held
  task automatic idle_check(input string tag);
    @(posedge clock);
    #1;
    chk1({tag, " ready after E33"}, ready, 1'b0);
    chk1({tag, " busy after E33"}, busy, 1'b0);
    chk32({tag, " out held after E33"}, out, last_out);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mo;
    logic        mv;
    int          stray;

    vecs[0] = '{32'd6,        32'd7,        32'd42,       1'b0};
    vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0};
    vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[3] = '{32'h80000000, 32'h00000001, 32'h80000000, 1'b0};
    vecs[4] = '{32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1};
    vecs[5] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};

    reset    = 1'b0;
    start    = 1'b0;
    A_in     = 32'd0;
    B_in     = 32'd0;
    last_out = 32'd0;

    #12;
    chk32("reset out", out, 32'd0);
    chk1("reset exp", exp, 1'b0);
    chk1("reset ready", ready, 1'b0);
    chk1("reset busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Directed table; odd entries run back-to-back with the next start at E33
    for (int i = 0; i < 6; i++) begin
      do_start(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      finish_op(vecs[i].want_out, vecs[i].want_ovf, $sformatf("vec%0d", i));
      if (i % 2 == 0) idle_check($sformatf("vec%0d", i));
    end
    idle_check("vec_end");

    // Random operands, mixing full-range and small signed values
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) begin
        ra = 32'($signed($urandom_range(0, 200)) - 100);
        rb = 32'($signed($urandom_range(0, 200)) - 100);
      end else if (i % 3 == 1) begin
        ra = $urandom & 32'h8000FFFF;
        rb = $urandom & 32'h0001FFFF;
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      model(ra, rb, mo, mv);
      do_start(ra, rb, $sformatf("rnd%0d", i));
      finish_op(mo, mv, $sformatf("rnd%0d", i));
      if (i % 4 == 3) idle_check($sformatf("rnd%0d", i));
    end
    idle_check("rnd_end");

    // Restart mid-RUN: only the second operation produces ready
    do_start(32'd100, 32'd100, "restart_first");
    stray = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      #1;
      if (ready !== 1'b0) stray++;
    end
    chk32("restart no early ready", 32'(stray), 32'd0);
    do_start(32'd2, 32'd3, "restart_second");
    finish_op(32'd6, 1'b0, "restart_second");
    idle_check("restart");
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (ready !== 1'b0) stray++;
    end
    chk32("restart single pulse", 32'(stray), 32'd0);

    // Reset in the middle of RUN clears everything at once
    do_start(32'd1234, 32'd5678, "rst_mid");
    repeat (14) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk1("rst_mid ready", ready, 1'b0);
    chk1("rst_mid busy", busy, 1'b0);
    chk32("rst_mid out", out, 32'd0);
    chk1("rst_mid exp", exp, 1'b0);
    last_out = 32'd0;
    @(negedge clock);
    reset = 1'b1;
    do_start(32'hFFFFFFFC, 32'hFFFFFFFC, "after_rst");
    finish_op(32'd16, 1'b0, "after_rst");
    idle_check("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential 32×32 signed multiplier using radix-2 Booth recoding, the multiply counterpart to the processor's multicycle divider. It sits beside the divider in the multdiv unit and uses the same start/ready handshake, so the pipeline stall logic treats both identically. It returns the low 32 bits of the product and flags results that do not fit in 32 signed bits.

## Interface
- ITERS, 32: Booth iterations, equal to the operand width; fixed, not overridable.
- clock  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle request; latches A_in/B_in.
- A_in  in  32  multiplicand, two's complement; sampled only on a start edge.
- B_in  in  32  multiplier, two's complement; sampled only on a start edge.
- out  out  32  product[31:0]; registered; held until the next result.
- exp  out  1  overflow; product[63:31] not all equal; registered with out.
- ready  out  1  one-cycle pulse: out/exp newly valid.
- busy  out  1  high while iterating (state RUN).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -start-> RUN
  - RUN -(count==31)-> DONE
  - DONE -> IDLE unconditionally, or DONE -start-> RUN
- start in any state, including RUN, aborts the current operation and restarts with fresh operands.
- Datapath registers:
  - mcand[32:0]: A_in sign-extended to 33 bits.
  - acc[32:0]: cleared on start.
  - mq[31:0]: loaded with B_in.
  - q_1: cleared on start.
  - count[4:0]: cleared on start.
- Each RUN cycle examines {mq[0], q_1}:
  - 01: acc += mcand
  - 10: acc -= mcand
  - 00/11: no operation
  - Then arithmetic right shift of {acc, mq, q_1} by 1, and count++.
- The 33-bit accumulator prevents intermediate overflow for A_in = 0x80000000.
- After 32 steps, product[63:0] = {acc[31:0], mq}.
  - out := mq
  - exp := ~(&product[63:31] | ~|product[63:31])
- out and exp update only on the RUN→DONE edge; ready is asserted only in DONE.

## Timing
- Reset values:
  - outputs: out=0, exp=0, ready=0, busy=0
  - internal: state=IDLE, acc=0, mq=0, q_1=0, count=0
- start high at edge E0 → state RUN, busy=1 from E0.
- Iterations execute on edges E1..E32; at E32, state→DONE and out/exp are loaded.
- ready=1 for exactly one cycle, E32 to E33; busy=0 from E32.
- Latency: ready asserts 32 cycles after the start edge, with the result visible in the same cycle.
- A_in/B_in may change freely after E0.
- start coinciding with DONE (edge E33): the new operation begins; ready deasserts; out/exp hold the previous result until the new E32.
- start during RUN: restart at that edge; no ready is produced for the aborted operation.
- Reset mid-RUN: immediate return to IDLE; outputs clear asynchronously.
- Back-to-back starts every 33 cycles sustain full throughput.

## Structure
- Package mult_pkg:
  - state enum (IDLE, RUN, DONE)
  - ITERS, WIDTH=32, ACC_W=33
  - Booth pair constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10)
- Sub-module booth_step, combinational:
  - inputs: acc, mq, q_1, mcand
  - outputs: next acc, mq, q_1 (add/subtract/none, then arithmetic shift)
  - Top level holds only the FSM, counter and registers.

## Test plan
- A=6, B=7: ready at cycle 32 after start; out=42, exp=0; busy low after.
- A=-3 (0xFFFFFFFD), B=5: out=0xFFFFFFF1 (-15), exp=0.
- A=0x80000000, B=0xFFFFFFFF: out=0x80000000, exp=1. A=0x80000000, B=1: out=0x80000000, exp=0.
- A=0x7FFFFFFF, B=2: out=0xFFFFFFFE, exp=1. A=0x00010000, B=0x00010000: out=0, exp=1.
- Restart: start(A=100, B=100), then start(A=2, B=3) at cycle 10 → a single ready pulse 32 cycles after the second start, with out=6; no pulse for the first operation.
- Reset low at cycle 15 of RUN → ready=0, busy=0, out=0 immediately; a following start(A=-4, B=-4) → out=16, exp=0.
